astar_neighbor_gen: RTL

Neighbour-expansion stage of the A* pathfinding engine, directly upstream of the open-list search. Given the current node popped from the open list, it walks the node's neighbours in a fixed order. It discards out-of-grid, wall and closed cells, computes each surviving neighbour's tentative g-cost, and hands that neighbour to the open-list search via a valid/ready handshake. It then waits for the search to finish before moving on.

---
 rtl/astar_pkg.sv | 44 ++++
 rtl/astar_dir_rom.sv | 31 +++
 rtl/astar_neighbor_gen.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/astar_pkg.sv
// Shared types and constants for the A* engine stages.
// ASTAR_DIAGONAL_EN selects 8-connectivity (default build is 4-connectivity).
package astar_pkg;

  localparam int GRID_W  = 20;
  localparam int GRID_H  = 20;
  localparam int COORD_W = 8;
  localparam int ADDR_W  = 9;
  localparam int COST_W  = 12;
  localparam int DIR_W   = 3;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COST_W-1:0]  cost_t;
  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [DIR_W-1:0]   dir_t;
  typedef logic signed [1:0]  offs_t;

  localparam cost_t COST_ORTHO = COST_W'(10);
  localparam cost_t COST_DIAG  = COST_W'(14);

`ifdef ASTAR_DIAGONAL_EN
  localparam dir_t LAST_DIR = 3'd7;
`else
  localparam dir_t LAST_DIR = 3'd3;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_BOUNDS,
    S_MAP_RD,
    S_MAP_WAIT,
    S_ISSUE,
    S_WAIT_RESULT,
    S_DONE
  } state_t;

  // g-costs clamp at the all-ones value instead of wrapping.
  function automatic cost_t sat_add(input cost_t a, input cost_t b);
    logic [COST_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[COST_W] ? '1 : s[COST_W-1:0];
  endfunction

endpackage

// File: rtl/astar_dir_rom.sv
// Direction table: dir -> neighbour offset and step cost.
// Diagonal entries 4-7 exist only when ASTAR_DIAGONAL_EN is defined.
module astar_dir_rom
  import astar_pkg::*;
(
  input  dir_t  dir_i,
  output offs_t dx_o,
  output offs_t dy_o,
  output cost_t step_o
);

  always_comb begin
    dx_o   = 2'sd0;
    dy_o   = 2'sd0;
    step_o = COST_ORTHO;
    case (dir_i)
      3'd0: dy_o = -2'sd1;
      3'd1: dx_o = 2'sd1;
      3'd2: dy_o = 2'sd1;
      3'd3: dx_o = -2'sd1;
`ifdef ASTAR_DIAGONAL_EN
      3'd4: begin dx_o = 2'sd1;  dy_o = -2'sd1; step_o = COST_DIAG; end
      3'd5: begin dx_o = 2'sd1;  dy_o = 2'sd1;  step_o = COST_DIAG; end
      3'd6: begin dx_o = -2'sd1; dy_o = 2'sd1;  step_o = COST_DIAG; end
      3'd7: begin dx_o = -2'sd1; dy_o = -2'sd1; step_o = COST_DIAG; end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/astar_neighbor_gen.sv
// A* neighbour expansion: walks the current node's neighbours and offers
// each in-grid, non-wall, non-closed one to the open-list search (ASTAR_DIAGONAL_EN: 8-conn).
module astar_neighbor_gen
  import astar_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   start_i,
  input  coord_t cur_x_i,
  input  coord_t cur_y_i,
  input  cost_t  cur_g_i,
  output logic   busy_o,
  output logic   done_o,
  output logic   map_rd_en_o,
  output addr_t  map_rd_addr_o,
  input  logic   map_wall_i,
  input  logic   map_closed_i,
  output logic   check_valid_o,
  output coord_t check_x_o,
  output coord_t check_y_o,
  output cost_t  check_g_o,
  input  logic   check_ready_i,
  input  logic   search_done_i,
  output logic [3:0] issued_cnt_o,
  output state_t state_o
);

  state_t     state_q, state_d;
  dir_t       dir_q, dir_d;
  coord_t     cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  cost_t      cur_g_q, cur_g_d;
  coord_t     nx_q, nx_d, ny_q, ny_d;
  cost_t      g_q, g_d;
  logic [3:0] issued_q, issued_d;

  offs_t dx, dy;
  cost_t step;
  logic signed [COORD_W:0] nx_s, ny_s;
  logic in_range, advance;

  astar_dir_rom u_dir_rom (
    .dir_i  (dir_q),
    .dx_o   (dx),
    .dy_o   (dy),
    .step_o (step)
  );

  assign nx_s = $signed({1'b0, cur_x_q}) + $signed({{(COORD_W-1){dx[1]}}, dx});
  assign ny_s = $signed({1'b0, cur_y_q}) + $signed({{(COORD_W-1){dy[1]}}, dy});
  assign in_range = !nx_s[COORD_W] && !ny_s[COORD_W]
                 && (nx_s[COORD_W-1:0] < COORD_W'(GRID_W))
                 && (ny_s[COORD_W-1:0] < COORD_W'(GRID_H));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      dir_q    <= '0;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      cur_g_q  <= '0;
      nx_q     <= '0;
      ny_q     <= '0;
      g_q      <= '0;
      issued_q <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      cur_g_q  <= cur_g_d;
      nx_q     <= nx_d;
      ny_q     <= ny_d;
      g_q      <= g_d;
      issued_q <= issued_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    cur_g_d  = cur_g_q;
    nx_d     = nx_q;
    ny_d     = ny_q;
    g_d      = g_q;
    issued_d = issued_q;
    advance  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cur_x_d  = cur_x_i;
          cur_y_d  = cur_y_i;
          cur_g_d  = cur_g_i;
          dir_d    = '0;
          issued_d = '0;
          state_d  = S_BOUNDS;
        end
      end
      S_BOUNDS: begin
        if (in_range) begin
          nx_d    = nx_s[COORD_W-1:0];
          ny_d    = ny_s[COORD_W-1:0];
          g_d     = sat_add(cur_g_q, step);
          state_d = S_MAP_RD;
        end else begin
          advance = 1'b1;
        end
      end
      S_MAP_RD:   state_d = S_MAP_WAIT;
      S_MAP_WAIT: begin
        if (map_wall_i || map_closed_i) advance = 1'b1;
        else                            state_d = S_ISSUE;
      end
      // Valid/ready: check_* stay stable while check_valid_o is high; the
      // neighbour transfers on the first cycle where check_ready_i is also high.
      S_ISSUE: begin
        if (check_ready_i) begin
          issued_d = issued_q + 4'd1;
          state_d  = S_WAIT_RESULT;
        end
      end
      S_WAIT_RESULT: if (search_done_i) advance = 1'b1;
      S_DONE:        state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
    if (advance) begin
      if (dir_q == LAST_DIR) begin
        state_d = S_DONE;
      end else begin
        dir_d   = dir_q + 3'd1;
        state_d = S_BOUNDS;
      end
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign map_rd_en_o   = (state_q == S_MAP_RD);
  assign map_rd_addr_o = ADDR_W'(ny_q * GRID_W + nx_q);
  assign check_valid_o = (state_q == S_ISSUE);
  assign check_x_o     = nx_q;
  assign check_y_o     = ny_q;
  assign check_g_o     = g_q;
  assign issued_cnt_o  = issued_q;
  assign state_o       = state_q;

endmodule
